bus_fabric: RTL and testbench
=============================

// Module: bus_fabric
// PURPOSE
//  Parametrised 2-master / N-slave interconnect for the ibex-protocol data bus; successor of the fixed 5-way bus_mux.
//  Arbitrates core data port (M0) and a second master (M1: bootloader/debug loader), decodes base/mask address map.
//  Routes one outstanding transaction at a time; unmapped accesses get an error response; optional response timeout.
// PARAMETERS
//  N_SLV     5               number of slave ports (1..16)
//  SLV_BASE  {N_SLV{32'h0}}  packed base addresses, slave i at [32*i +: 32]; default top-level map set by instantiation
//  SLV_MASK  {N_SLV{32'h0}}  packed masks; hit(i) = (addr & MASK[i]) == BASE[i]
//  ARB_RR    1               1: round-robin between M0/M1; 0: fixed priority, M0 wins
//  TIMEOUT   255             response timeout in cycles (used only with BUS_FABRIC_TIMEOUT_EN), 1..65535
//  ERR_RDATA 32'hBADADD00    rdata returned with every error response
// PORTS
//  clk         in   1        system clock
//  rst_n       in   1        asynchronous active-low reset
//  mst_req     in   2        request, bit m = master m
//  mst_we      in   2        write enable per master
//  mst_be      in   2x4      byte enables per master
//  mst_addr    in   2x32     address per master
//  mst_wdata   in   2x32     write data per master
//  mst_gnt     out  2        grant per master
//  mst_rvalid  out  2        response valid per master
//  mst_rdata   out  32       read data (shared, qualified by mst_rvalid)
//  mst_err     out  1        error (shared, qualified by mst_rvalid)
//  slv_req     out  N_SLV    request one-hot
//  slv_we/be/addr/wdata out 1/4/32/32  broadcast from granted master
//  slv_gnt     in   N_SLV    slave grant
//  slv_rvalid  in   N_SLV    slave response valid
//  slv_rdata   in   N_SLVx32 packed slave read data
//  slv_err     in   N_SLV    slave error
//  bus_err     out  1        one-cycle pulse on any fabric-generated error
//  err_addr    out  32       address of last fabric-generated error
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; err_addr 0; RR pointer -> M0; lock cleared.
//  IDLE: pick winner (RR pointer / M0 priority). Winner locked until granted: a later request from the other
//   master never preempts a presented, ungranted one (ibex keeps req/addr stable until gnt).
//  Decode: lowest index i with hit(i) wins (overlap resolution). slv_req[i] and broadcast signals driven
//   combinationally from the winner; mst_gnt[w] = slv_gnt[i] in the same cycle (zero added latency).
//  On gnt: latch owner w and slave i -> WAIT_RESP; RR pointer moves to the other master.
//  Miss (no hit): mst_gnt[w]=1 immediately, latch addr into err_addr -> ERR_RESP.
//  WAIT_RESP: mst_gnt=0, slv_req=0. On slv_rvalid[i]: mst_rvalid[w]=1, mst_rdata=slv_rdata[i],
//   mst_err=slv_err[i] (combinational passthrough) -> IDLE. New address phase earliest next cycle.
//  ERR_RESP: one cycle: mst_rvalid[w]=1, mst_err=1, mst_rdata=ERR_RDATA, bus_err=1 -> IDLE.
//  slv_rvalid from non-selected slave, or while IDLE: ignored.
//  mst_rdata=0, mst_err=0 whenever no mst_rvalid.
//  Min access: 1-cycle gnt + response; max throughput 1 transaction per 2 cycles.
//  rst_n low mid-transaction: outstanding transaction dropped, no response issued; all outputs return to reset values.
// CONFIGURATION
//  BUS_FABRIC_TIMEOUT_EN defined: 16-bit counter cleared on entering WAIT_RESP, counts each WAIT_RESP cycle.
//   When it reaches TIMEOUT without slv_rvalid[i]: error response as in ERR_RESP (rdata ERR_RDATA, bus_err pulse,
//   err_addr = timed-out address) -> IDLE. A late slv_rvalid from that slave is then ignored.
//  Not defined: no counter; WAIT_RESP waits indefinitely.
// TESTING
//  1 M0 read 0x0000_0010 (RAM hit, slave 0 gnt same cycle, rvalid +1 rdata 0x12345678) -> mst_gnt[0] same cycle, rvalid[0] rdata 0x12345678
//  2 M0 and M1 req together, ARB_RR=1, M0 addr 0x0001_0000, M1 addr 0x0002_0004 -> M0 granted first, M1 next, slv_req one-hot 2 then 4
//  3 M1 write 0x00FF_0000 (unmapped) -> gnt same cycle, next cycle rvalid[1], err=1, rdata 0xBADADD00, bus_err pulse, err_addr 0x00FF_0000
//  4 slave 3 holds slv_gnt low 5 cycles while M1 asserts req -> M0 req arriving mid-wait not granted until M1 completes
//  5 TIMEOUT_EN, TIMEOUT=8, slave never rvalids -> err response exactly 8 cycles after gnt; later slv_rvalid ignored
//  6 rst_n low in WAIT_RESP -> no mst_rvalid; after release first request serviced normally, RR pointer M0

Source files
------------

// File: rtl/bus_fabric.sv
// bus_fabric: 2-master / N-slave ibex data-bus interconnect, one transaction in flight.
// Optional response timeout enabled by defining BUS_FABRIC_TIMEOUT_EN.
module bus_fabric #(
  parameter int unsigned          N_SLV     = 5,
  parameter logic [32*N_SLV-1:0]  SLV_BASE  = {N_SLV{32'h0}},
  parameter logic [32*N_SLV-1:0]  SLV_MASK  = {N_SLV{32'h0}},
  parameter bit                   ARB_RR    = 1'b1,
  parameter int unsigned          TIMEOUT   = 255,
  parameter logic [31:0]          ERR_RDATA = 32'hBADADD00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mst_req,
  input  logic [1:0]           mst_we,
  input  logic [7:0]           mst_be,
  input  logic [63:0]          mst_addr,
  input  logic [63:0]          mst_wdata,
  output logic [1:0]           mst_gnt,
  output logic [1:0]           mst_rvalid,
  output logic [31:0]          mst_rdata,
  output logic                 mst_err,
  output logic [N_SLV-1:0]     slv_req,
  output logic                 slv_we,
  output logic [3:0]           slv_be,
  output logic [31:0]          slv_addr,
  output logic [31:0]          slv_wdata,
  input  logic [N_SLV-1:0]     slv_gnt,
  input  logic [N_SLV-1:0]     slv_rvalid,
  input  logic [32*N_SLV-1:0]  slv_rdata,
  input  logic [N_SLV-1:0]     slv_err,
  output logic                 bus_err,
  output logic [31:0]          err_addr
);

  localparam int unsigned SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RESP,
    ERR_RESP
  } state_e;

  state_e        state_q, state_d;
  logic          own_q, own_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          rr_q, rr_d;
  logic          lock_vld_q, lock_vld_d;
  logic          lock_mst_q, lock_mst_d;
  logic [31:0]   err_addr_q, err_addr_d;
`ifdef BUS_FABRIC_TIMEOUT_EN
  logic [15:0]   cnt_q, cnt_d;
  logic [31:0]   taddr_q, taddr_d;
`endif

  logic          win;
  logic          win_req;
  logic          win_we;
  logic [3:0]    win_be;
  logic [31:0]   win_addr;
  logic [31:0]   win_wdata;
  logic          hit_any;
  logic [SW-1:0] hit_idx;

  // Pick the master for this address phase; a presented, ungranted one keeps the bus.
  always_comb begin
    win = 1'b0;
    if (lock_vld_q && mst_req[lock_mst_q]) begin
      win = lock_mst_q;
    end else if (mst_req == 2'b11) begin
      win = ARB_RR ? rr_q : 1'b0;
    end else begin
      win = mst_req[1];
    end
    win_req   = mst_req[win];
    win_we    = mst_we[win];
    win_be    = win ? mst_be[7:4]      : mst_be[3:0];
    win_addr  = win ? mst_addr[63:32]  : mst_addr[31:0];
    win_wdata = win ? mst_wdata[63:32] : mst_wdata[31:0];
  end

  // Address decode; scanning downwards leaves the lowest matching slave.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((win_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit_any = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  // Next-state and routing of request/response paths.
  always_comb begin
    state_d    = state_q;
    own_d      = own_q;
    sel_d      = sel_q;
    rr_d       = rr_q;
    lock_vld_d = lock_vld_q;
    lock_mst_d = lock_mst_q;
    err_addr_d = err_addr_q;
`ifdef BUS_FABRIC_TIMEOUT_EN
    cnt_d      = cnt_q;
    taddr_d    = taddr_q;
`endif
    mst_gnt    = '0;
    mst_rvalid = '0;
    mst_rdata  = '0;
    mst_err    = 1'b0;
    slv_req    = '0;
    slv_we     = 1'b0;
    slv_be     = '0;
    slv_addr   = '0;
    slv_wdata  = '0;
    bus_err    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_req) begin
          slv_we    = win_we;
          slv_be    = win_be;
          slv_addr  = win_addr;
          slv_wdata = win_wdata;
          if (hit_any) begin
            slv_req[hit_idx] = 1'b1;
            mst_gnt[win]     = slv_gnt[hit_idx];
            if (slv_gnt[hit_idx]) begin
              state_d    = WAIT_RESP;
              own_d      = win;
              sel_d      = hit_idx;
              rr_d       = ~win;
              lock_vld_d = 1'b0;
`ifdef BUS_FABRIC_TIMEOUT_EN
              cnt_d      = '0;
              taddr_d    = win_addr;
`endif
            end else begin
              lock_vld_d = 1'b1;
              lock_mst_d = win;
            end
          end else begin
            mst_gnt[win] = 1'b1;
            err_addr_d   = win_addr;
            state_d      = ERR_RESP;
            own_d        = win;
            rr_d         = ~win;
            lock_vld_d   = 1'b0;
          end
        end else begin
          lock_vld_d = 1'b0;
        end
      end

      WAIT_RESP: begin
        if (slv_rvalid[sel_q]) begin
          mst_rvalid[own_q] = 1'b1;
          mst_rdata         = slv_rdata[32*sel_q +: 32];
          mst_err           = slv_err[sel_q];
          state_d           = IDLE;
        end
`ifdef BUS_FABRIC_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == 16'(TIMEOUT)) begin
            mst_rvalid[own_q] = 1'b1;
            mst_err           = 1'b1;
            mst_rdata         = ERR_RDATA;
            bus_err           = 1'b1;
            err_addr_d        = taddr_q;
            state_d           = IDLE;
          end
        end
`endif
      end

      ERR_RESP: begin
        mst_rvalid[own_q] = 1'b1;
        mst_err           = 1'b1;
        mst_rdata         = ERR_RDATA;
        bus_err           = 1'b1;
        state_d           = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, ownership, arbitration and error-address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      own_q      <= 1'b0;
      sel_q      <= '0;
      rr_q       <= 1'b0;
      lock_vld_q <= 1'b0;
      lock_mst_q <= 1'b0;
      err_addr_q <= '0;
`ifdef BUS_FABRIC_TIMEOUT_EN
      cnt_q      <= '0;
      taddr_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      sel_q      <= sel_d;
      rr_q       <= rr_d;
      lock_vld_q <= lock_vld_d;
      lock_mst_q <= lock_mst_d;
      err_addr_q <= err_addr_d;
`ifdef BUS_FABRIC_TIMEOUT_EN
      cnt_q      <= cnt_d;
      taddr_q    <= taddr_d;
`endif
    end
  end

  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: directed checks of bus_fabric arbitration, decode and responses.
// Timeout scenario is exercised when BUS_FABRIC_TIMEOUT_EN is defined.
module tb_bus_fabric;

  localparam int N = 5;

  logic          clk;
  logic          rst_n;
  logic [1:0]    mst_req;
  logic [1:0]    mst_we;
  logic [7:0]    mst_be;
  logic [63:0]   mst_addr;
  logic [63:0]   mst_wdata;
  logic [1:0]    mst_gnt;
  logic [1:0]    mst_rvalid;
  logic [31:0]   mst_rdata;
  logic          mst_err;
  logic [N-1:0]  slv_req;
  logic          slv_we;
  logic [3:0]    slv_be;
  logic [31:0]   slv_addr;
  logic [31:0]   slv_wdata;
  logic [N-1:0]  slv_gnt;
  logic [N-1:0]  slv_rvalid;
  logic [32*N-1:0] slv_rdata;
  logic [N-1:0]  slv_err;
  logic          bus_err;
  logic [31:0]   err_addr;

  int checks;
  int errors;

  bus_fabric #(
    .N_SLV    (N),
    .SLV_BASE ({32'h0010_0000, 32'h0010_0000, 32'h0002_0000,
                32'h0001_0000, 32'h0000_0000}),
    .SLV_MASK ({32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                32'hFFFF_0000, 32'hFFFF_0000}),
    .ARB_RR   (1'b1),
    .TIMEOUT  (8),
    .ERR_RDATA(32'hBADADD00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mst_req   (mst_req),
    .mst_we    (mst_we),
    .mst_be    (mst_be),
    .mst_addr  (mst_addr),
    .mst_wdata (mst_wdata),
    .mst_gnt   (mst_gnt),
    .mst_rvalid(mst_rvalid),
    .mst_rdata (mst_rdata),
    .mst_err   (mst_err),
    .slv_req   (slv_req),
    .slv_we    (slv_we),
    .slv_be    (slv_be),
    .slv_addr  (slv_addr),
    .slv_wdata (slv_wdata),
    .slv_gnt   (slv_gnt),
    .slv_rvalid(slv_rvalid),
    .slv_rdata (slv_rdata),
    .slv_err   (slv_err),
    .bus_err   (bus_err),
    .err_addr  (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_inputs();
    mst_req    = '0;
    mst_we     = '0;
    mst_be     = '0;
    mst_addr   = '0;
    mst_wdata  = '0;
    slv_gnt    = '0;
    slv_rvalid = '0;
    slv_rdata  = '0;
    slv_err    = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clr_inputs();

    // reset state
    step();
    step();
    settle();
    chk("rst_gnt", 32'(mst_gnt), 32'h0);
    chk("rst_rvalid", 32'(mst_rvalid), 32'h0);
    chk("rst_slv_req", 32'(slv_req), 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    step();
    rst_n = 1'b1;

    // both masters request: M0 first (pointer at M0), then M1
    step();
    mst_req   = 2'b11;
    mst_we    = 2'b10;
    mst_be    = 8'hCF;
    mst_addr  = {32'h0002_0004, 32'h0001_0000};
    mst_wdata = {32'hCAFE_F00D, 32'h0};
    slv_gnt   = 5'b00110;
    settle();
    chk("rr_slv_req0", 32'(slv_req), 32'h2);
    chk("rr_gnt0", 32'(mst_gnt), 32'h1);
    chk("rr_addr0", slv_addr, 32'h0001_0000);
    step();
    mst_req = 2'b10;
    slv_rvalid = 5'b00010;
    slv_rdata[32*1 +: 32] = 32'hAAAA_0001;
    settle();
    chk("rr_rvalid0", 32'(mst_rvalid), 32'h1);
    chk("rr_rdata0", mst_rdata, 32'hAAAA_0001);
    chk("rr_wait_req", 32'(slv_req), 32'h0);
    chk("rr_wait_gnt", 32'(mst_gnt), 32'h0);
    step();
    slv_rvalid = '0;
    settle();
    chk("rr_slv_req1", 32'(slv_req), 32'h4);
    chk("rr_gnt1", 32'(mst_gnt), 32'h2);
    chk("rr_addr1", slv_addr, 32'h0002_0004);
    chk("rr_we1", 32'(slv_we), 32'h1);
    chk("rr_be1", 32'(slv_be), 32'hC);
    chk("rr_wdata1", slv_wdata, 32'hCAFE_F00D);
    step();
    clr_inputs();
    slv_rvalid = 5'b00100;
    slv_rdata[32*2 +: 32] = 32'hBBBB_0002;
    settle();
    chk("rr_rvalid1", 32'(mst_rvalid), 32'h2);
    chk("rr_rdata1", mst_rdata, 32'hBBBB_0002);

    // M0 read of RAM, same-cycle grant, response next cycle
    step();
    clr_inputs();
    mst_req  = 2'b01;
    mst_addr = {32'h0, 32'h0000_0010};
    slv_gnt  = 5'b00001;
    settle();
    chk("rd_slv_req", 32'(slv_req), 32'h1);
    chk("rd_gnt", 32'(mst_gnt), 32'h1);
    step();
    clr_inputs();
    slv_rvalid = 5'b00001;
    slv_rdata[31:0] = 32'h1234_5678;
    settle();
    chk("rd_rvalid", 32'(mst_rvalid), 32'h1);
    chk("rd_rdata", mst_rdata, 32'h1234_5678);
    chk("rd_err", 32'(mst_err), 32'h0);
    step();
    settle();
    chk("idle_rvalid_ign", 32'(mst_rvalid), 32'h0);
    chk("idle_rdata_zero", mst_rdata, 32'h0);

    // M1 write to unmapped address
    step();
    clr_inputs();
    mst_req  = 2'b10;
    mst_we   = 2'b10;
    mst_addr = {32'h00FF_0000, 32'h0};
    slv_gnt  = '1;
    settle();
    chk("miss_gnt", 32'(mst_gnt), 32'h2);
    chk("miss_slv_req", 32'(slv_req), 32'h0);
    step();
    clr_inputs();
    settle();
    chk("miss_rvalid", 32'(mst_rvalid), 32'h2);
    chk("miss_err", 32'(mst_err), 32'h1);
    chk("miss_rdata", mst_rdata, 32'hBADADD00);
    chk("miss_bus_err", 32'(bus_err), 32'h1);
    chk("miss_err_addr", err_addr, 32'h00FF_0000);
    step();
    settle();
    chk("miss_bus_err_end", 32'(bus_err), 32'h0);
    chk("miss_rvalid_end", 32'(mst_rvalid), 32'h0);

    // M1 stalled on slave 3 keeps the bus against a later M0 request
    step();
    clr_inputs();
    mst_req  = 2'b10;
    mst_addr = {32'h0010_0008, 32'h0};
    settle();
    chk("lock_slv_req", 32'(slv_req), 32'h8);
    chk("lock_gnt_wait", 32'(mst_gnt), 32'h0);
    step();
    for (int k = 2; k < 5; k++) begin
      step();
      mst_req  = 2'b11;
      mst_addr = {32'h0010_0008, 32'h0000_0020};
      settle();
      chk("lock_no_gnt", 32'(mst_gnt), 32'h0);
      chk("lock_addr", slv_addr, 32'h0010_0008);
    end
    step();
    slv_gnt = 5'b01000;
    settle();
    chk("lock_gnt1", 32'(mst_gnt), 32'h2);
    step();
    mst_req    = 2'b01;
    slv_gnt    = '0;
    slv_rvalid = 5'b00010;
    settle();
    chk("other_rvalid_ign", 32'(mst_rvalid), 32'h0);
    step();
    slv_rvalid = 5'b01000;
    slv_err    = 5'b01000;
    slv_rdata[32*3 +: 32] = 32'h3333_0003;
    settle();
    chk("lock_rvalid1", 32'(mst_rvalid), 32'h2);
    chk("lock_rdata1", mst_rdata, 32'h3333_0003);
    chk("lock_err1", 32'(mst_err), 32'h1);
    step();
    slv_rvalid = '0;
    slv_err    = '0;
    slv_gnt    = 5'b00001;
    settle();
    chk("lock_m0_req", 32'(slv_req), 32'h1);
    chk("lock_m0_gnt", 32'(mst_gnt), 32'h1);
    step();
    clr_inputs();
    slv_rvalid = 5'b00001;
    slv_rdata[31:0] = 32'h0000_0020;
    settle();
    chk("lock_m0_rvalid", 32'(mst_rvalid), 32'h1);

`ifdef BUS_FABRIC_TIMEOUT_EN
    // slave 1 never responds: error exactly 8 cycles after grant
    step();
    clr_inputs();
    mst_req  = 2'b01;
    mst_addr = {32'h0, 32'h0001_0000};
    slv_gnt  = 5'b00010;
    settle();
    chk("to_gnt", 32'(mst_gnt), 32'h1);
    for (int k = 1; k < 8; k++) begin
      step();
      clr_inputs();
      settle();
      chk("to_waiting", 32'(mst_rvalid), 32'h0);
    end
    step();
    settle();
    chk("to_rvalid", 32'(mst_rvalid), 32'h1);
    chk("to_err", 32'(mst_err), 32'h1);
    chk("to_rdata", mst_rdata, 32'hBADADD00);
    chk("to_bus_err", 32'(bus_err), 32'h1);
    step();
    slv_rvalid = 5'b00010;
    settle();
    chk("to_err_addr", err_addr, 32'h0001_0000);
    chk("to_late_ign", 32'(mst_rvalid), 32'h0);
`endif

    // reset in WAIT_RESP drops the transaction and the RR pointer
    step();
    clr_inputs();
    mst_req  = 2'b01;
    mst_addr = {32'h0, 32'h0000_0010};
    slv_gnt  = 5'b00001;
    settle();
    chk("rw_gnt", 32'(mst_gnt), 32'h1);
    step();
    clr_inputs();
    rst_n      = 1'b0;
    slv_rvalid = 5'b00001;
    settle();
    chk("rw_no_rvalid", 32'(mst_rvalid), 32'h0);
    chk("rw_err_addr", err_addr, 32'h0);
    step();
    rst_n = 1'b1;
    settle();
    chk("rw_post_ign", 32'(mst_rvalid), 32'h0);
    step();
    slv_rvalid = '0;
    mst_req    = 2'b11;
    mst_addr   = {32'h0002_0004, 32'h0001_0000};
    slv_gnt    = 5'b00110;
    settle();
    chk("rw_rr_m0", 32'(mst_gnt), 32'h1);
    chk("rw_slv_req", 32'(slv_req), 32'h2);
    step();
    clr_inputs();
    slv_rvalid = 5'b00010;
    slv_rdata[32*1 +: 32] = 32'h5555_AAAA;
    settle();
    chk("rw_rdata", mst_rdata, 32'h5555_AAAA);
    step();
    clr_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
